// File: rtl/scarv_cop_mem_seq.sv
// Memory transaction sequencer: serialises one batch of up to NSLOTS word accesses onto cop_mem_*.
// Optional abort port is enabled by defining SCARV_COP_MEM_SEQ_ABORT_EN.
module scarv_cop_mem_seq #(
  parameter int NSLOTS      = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NSLOTS-1:0]     req_cen,
  input  logic [NSLOTS-1:0]     req_wen,
  input  logic [4*NSLOTS-1:0]   req_ben,
  input  logic [32*NSLOTS-1:0]  req_addr,
  input  logic [32*NSLOTS-1:0]  req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_error,
  output logic [32*NSLOTS-1:0]  rsp_rdata,
  input  logic                  rsp_ack,
`ifdef SCARV_COP_MEM_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  cop_mem_cen,
  output logic                  cop_mem_wen,
  output logic [31:0]           cop_mem_addr,
  output logic [31:0]           cop_mem_wdata,
  output logic [3:0]            cop_mem_ben,
  input  logic [31:0]           cop_mem_rdata,
  input  logic                  cop_mem_stall,
  input  logic                  cop_mem_error
);

  localparam int PW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int CW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [CW-1:0] WD_MAX = (STALL_LIMIT > 0) ? CW'(STALL_LIMIT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [NSLOTS-1:0]        r_pend;
  logic [NSLOTS-1:0]        r_wen;
  logic [NSLOTS-1:0][3:0]   r_ben;
  logic [NSLOTS-1:0][31:0]  r_addr;
  logic [NSLOTS-1:0][31:0]  r_wdata;
  logic [NSLOTS-1:0][31:0]  r_rdata;
  logic                     r_error;
  logic [CW-1:0]            r_stall_cnt;

  logic [PW-1:0]            w_ptr;
  logic [NSLOTS-1:0]        w_pend_rest;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_wd_fire;
  logic                     w_abort;

`ifdef SCARV_COP_MEM_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Current slot is always the lowest still-pending one, so order is ascending by construction.
  always_comb begin
    w_ptr = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (r_pend[i]) w_ptr = PW'(i);
    end
  end

  assign w_pend_rest = r_pend & ~(NSLOTS'(1) << w_ptr);
  assign w_last      = (w_pend_rest == '0);
  assign w_accept    = (r_state == S_ISSUE) && !cop_mem_stall;
  assign w_wd_fire   = (STALL_LIMIT != 0) && (r_state == S_ISSUE) && cop_mem_stall &&
                       (r_stall_cnt == WD_MAX);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_state_nxt = (|req_cen) ? S_ISSUE : S_RESP;
      end
      S_ISSUE: begin
        if (w_abort)                                   w_state_nxt = S_IDLE;
        else if (w_accept && (cop_mem_error || w_last)) w_state_nxt = S_RESP;
        else if (w_wd_fire)                            w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_abort || rsp_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_wen       <= '0;
      r_ben       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_error     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_pend      <= req_cen;
            r_wen       <= req_wen;
            r_ben       <= req_ben;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_rdata     <= '0;
            r_error     <= 1'b0;
            r_stall_cnt <= '0;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            if (!r_wen[w_ptr]) r_rdata[w_ptr] <= cop_mem_rdata;
            if (cop_mem_error) r_error <= 1'b1;
            r_pend      <= cop_mem_error ? '0 : w_pend_rest;
            r_stall_cnt <= '0;
          end else if (w_wd_fire) begin
            r_error     <= 1'b1;
            r_pend      <= '0;
            r_stall_cnt <= '0;
          end else if (STALL_LIMIT != 0) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
          end
          // An accept in the abort cycle still lands; everything after it is dropped.
          if (w_abort) begin
            r_pend      <= '0;
            r_stall_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign rsp_valid     = (r_state == S_RESP);
  assign rsp_error     = r_error;
  assign rsp_rdata     = r_rdata;

  assign cop_mem_cen   = (r_state == S_ISSUE);
  assign cop_mem_wen   = r_wen[w_ptr];
  assign cop_mem_addr  = {r_addr[w_ptr][31:2], 2'b00};
  assign cop_mem_wdata = r_wdata[w_ptr];
  assign cop_mem_ben   = r_ben[w_ptr];

endmodule

// File: tb/tb_scarv_cop_mem_seq.sv
// Bench for scarv_cop_mem_seq: scripted and random batches against a slot-level memory model.
module tb_scarv_cop_mem_seq;

  localparam int LIMIT = 4;

  logic         g_clk = 1'b0;
  logic         g_resetn = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_cen = '0;
  logic [3:0]   req_wen = '0;
  logic [15:0]  req_ben = '0;
  logic [127:0] req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_error;
  logic [127:0] rsp_rdata;
  logic         rsp_ack = 1'b0;
`ifdef SCARV_COP_MEM_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         cop_mem_cen;
  logic         cop_mem_wen;
  logic [31:0]  cop_mem_addr;
  logic [31:0]  cop_mem_wdata;
  logic [3:0]   cop_mem_ben;
  logic [31:0]  cop_mem_rdata = '0;
  logic         cop_mem_stall = 1'b0;
  logic         cop_mem_error = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // Memory behaviour per slot: stall cycles before accept, error on accept, read data.
  int          m_stall [4];
  logic        m_err   [4];
  logic [31:0] m_rdata [4];

  // Results of the most recent run_batch.
  int           res_cyc;
  int           res_lat;
  logic         res_err;
  logic [127:0] res_rdata;
  logic [31:0]  res_first_addr;

  scarv_cop_mem_seq #(.NSLOTS(4), .STALL_LIMIT(LIMIT)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_cen(req_cen), .req_wen(req_wen),
    .req_ben(req_ben), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata), .rsp_ack(rsp_ack),
`ifdef SCARV_COP_MEM_SEQ_ABORT_EN
    .abort(abort),
`endif
    .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen), .cop_mem_addr(cop_mem_addr),
    .cop_mem_wdata(cop_mem_wdata), .cop_mem_ben(cop_mem_ben), .cop_mem_rdata(cop_mem_rdata),
    .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // Issues one batch, plays the memory, then checks the response against the slot-level model.
  task automatic run_batch(input logic [3:0] cen, input logic [3:0] wen, input logic [15:0] ben,
                           input logic [127:0] addr, input logic [127:0] wdata, input int hold);
    int exp_code, got_code, exp_cyc, bad, unstable, hold_bad, j;
    int used [4];
    logic exp_err, stop, prev_stall, p_wen;
    logic [127:0] exp_rdata;
    logic [31:0] p_addr, p_wdata;
    logic [3:0] p_ben;

    exp_err = 1'b0; stop = 1'b0; exp_rdata = '0; exp_cyc = 0; exp_code = 0;
    for (int k = 0; k < 4; k++) begin
      if (cen[k] && !stop) begin
        if (m_stall[k] >= LIMIT) begin
          exp_cyc += LIMIT; exp_err = 1'b1; stop = 1'b1;
        end else begin
          exp_cyc += m_stall[k] + 1;
          exp_code = exp_code * 5 + k + 1;
          if (!wen[k]) exp_rdata[k*32 +: 32] = m_rdata[k];
          if (m_err[k]) begin exp_err = 1'b1; stop = 1'b1; end
        end
      end
    end

    for (int k = 0; k < 20 && req_ready !== 1'b1; k++) @(negedge g_clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_cen = cen; req_wen = wen; req_ben = ben;
    req_addr = addr; req_wdata = wdata;
    @(negedge g_clk);
    req_valid = 1'b0;

    res_cyc = 0; res_lat = 0; res_first_addr = '0; got_code = 0; bad = 0; unstable = 0;
    prev_stall = 1'b0; p_addr = '0; p_wdata = '0; p_ben = '0; p_wen = 1'b0;
    for (int k = 0; k < 4; k++) used[k] = 0;
    for (int n = 1; n <= 200 && res_lat == 0; n++) begin
      if (n > 1) @(negedge g_clk);
      cop_mem_stall = 1'b0; cop_mem_error = 1'b0; cop_mem_rdata = $urandom;
      if (rsp_valid === 1'b1) begin
        res_lat = n;
      end else if (cop_mem_cen === 1'b1) begin
        if (res_cyc == 0) res_first_addr = cop_mem_addr;
        res_cyc++;
        j = -1;
        for (int k = 0; k < 4; k++)
          if (cen[k] && {addr[k*32+2 +: 30], 2'b00} === cop_mem_addr) j = k;
        if (j < 0) bad++;
        else if (cop_mem_wen !== wen[j] ||
                 (wen[j] && (cop_mem_wdata !== wdata[j*32 +: 32] || cop_mem_ben !== ben[j*4 +: 4])))
          bad++;
        if (prev_stall && {cop_mem_addr, cop_mem_wdata, cop_mem_ben, cop_mem_wen} !==
                          {p_addr, p_wdata, p_ben, p_wen})
          unstable++;
        p_addr = cop_mem_addr; p_wdata = cop_mem_wdata; p_ben = cop_mem_ben; p_wen = cop_mem_wen;
        if (j >= 0 && used[j] < m_stall[j]) begin
          used[j]++; cop_mem_stall = 1'b1; prev_stall = 1'b1;
        end else begin
          prev_stall = 1'b0;
          if (j >= 0) begin
            got_code = got_code * 5 + j + 1;
            cop_mem_error = m_err[j];
            cop_mem_rdata = m_rdata[j];
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
    end

    res_err = rsp_error; res_rdata = rsp_rdata;
    n_checks++;
    if (res_lat != exp_cyc + 1) begin
      n_fail++; $display("FAIL latency: rsp_valid at cycle %0d required %0d", res_lat, exp_cyc + 1);
    end
    n_checks++;
    if (res_cyc != exp_cyc) begin
      n_fail++; $display("FAIL cen_cycles: %0d required %0d", res_cyc, exp_cyc);
    end
    n_checks++;
    if (got_code != exp_code) begin
      n_fail++; $display("FAIL slot_order: code %0d required %0d", got_code, exp_code);
    end
    n_checks++;
    if (bad != 0 || unstable != 0) begin
      n_fail++; $display("FAIL port_drive: bad=%0d unstable=%0d required 0 0", bad, unstable);
    end
    n_checks++;
    if (res_err !== exp_err) begin
      n_fail++; $display("FAIL rsp_error: %b required %b", res_err, exp_err);
    end
    n_checks++;
    if (res_rdata !== exp_rdata) begin
      n_fail++; $display("FAIL rsp_rdata: %h required %h", res_rdata, exp_rdata);
    end

    hold_bad = (req_ready !== 1'b0) ? 1 : 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge g_clk);
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== res_rdata ||
          rsp_error !== res_err || cop_mem_cen !== 1'b0)
        hold_bad++;
    end
    rsp_ack = 1'b1;
    @(negedge g_clk);
    rsp_ack = 1'b0;
    n_checks++;
    if (hold_bad != 0) begin
      n_fail++; $display("FAIL resp_hold: %0d unstable cycles required 0", hold_bad);
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ack_release: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic clear_mem;
    for (int k = 0; k < 4; k++) begin
      m_stall[k] = 0; m_err[k] = 1'b0; m_rdata[k] = '0;
    end
  endtask

  task automatic test_reset;
    g_resetn = 1'b0;
    repeat (3) @(negedge g_clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || cop_mem_cen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b valid=%b cen=%b required 1 0 0", req_ready, rsp_valid, cop_mem_cen);
    end
    n_checks++;
    if (rsp_error !== 1'b0 || rsp_rdata !== '0) begin
      n_fail++; $display("FAIL reset_rsp: error=%b rdata=%h required 0 0", rsp_error, rsp_rdata);
    end
    g_resetn = 1'b1;
    @(negedge g_clk);
  endtask

  task automatic test_read_two;
    clear_mem();
    m_rdata[0] = 32'hA5A5A5A5; m_rdata[2] = 32'h12345678;
    run_batch(4'b0101, 4'b0000, 16'h0, {32'h0, 32'h208, 32'h0, 32'h100}, '0, 2);
    n_checks++;
    if (res_cyc != 2 || res_lat != 3 || res_err !== 1'b0 ||
        res_rdata !== {32'h0, 32'h12345678, 32'h0, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL read_two: cyc=%0d lat=%0d err=%b rdata=%h required 2 3 0 with A5A5A5A5/12345678",
               res_cyc, res_lat, res_err, res_rdata);
    end
  endtask

  task automatic test_write_stall;
    clear_mem();
    m_stall[1] = 3;
    run_batch(4'b0010, 4'b0010, 16'h0060, {32'h0, 32'h0, 32'h103, 32'h0},
              {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, 1);
    n_checks++;
    if (res_first_addr !== 32'h100 || res_cyc != 4 || res_lat != 5 || res_rdata !== '0) begin
      n_fail++;
      $display("FAIL write_stall: addr=%h cyc=%0d lat=%0d rdata=%h required 100 4 5 0",
               res_first_addr, res_cyc, res_lat, res_rdata);
    end
  endtask

  task automatic test_error;
    clear_mem();
    for (int k = 0; k < 4; k++) m_rdata[k] = 32'h5000_0000 + k;
    m_err[1] = 1'b1;
    run_batch(4'b1111, 4'b0000, 16'h0, {32'h10C0, 32'h1080, 32'h1040, 32'h1000}, '0, 0);
    n_checks++;
    if (res_err !== 1'b1 || res_cyc != 2 || res_rdata[31:0] !== 32'h5000_0000) begin
      n_fail++;
      $display("FAIL mem_error: err=%b cyc=%0d rdata0=%h required 1 2 50000000",
               res_err, res_cyc, res_rdata[31:0]);
    end
  endtask

  task automatic test_watchdog;
    clear_mem();
    m_stall[0] = 20;
    run_batch(4'b0001, 4'b0000, 16'h0, {96'h0, 32'h3000}, '0, 0);
    n_checks++;
    if (res_cyc != LIMIT || res_err !== 1'b1) begin
      n_fail++; $display("FAIL watchdog: cyc=%0d err=%b required %0d 1", res_cyc, res_err, LIMIT);
    end
    clear_mem();
    m_stall[0] = 1; m_stall[2] = LIMIT; m_rdata[0] = 32'h0BADCAFE;
    run_batch(4'b0101, 4'b0000, 16'h0, {32'h0, 32'h3080, 32'h0, 32'h3000}, '0, 1);
    n_checks++;
    if (res_cyc != 2 + LIMIT || res_err !== 1'b1 || res_rdata[31:0] !== 32'h0BADCAFE) begin
      n_fail++;
      $display("FAIL watchdog_edge: cyc=%0d err=%b rdata0=%h required %0d 1 0badcafe",
               res_cyc, res_err, res_rdata[31:0], 2 + LIMIT);
    end
  endtask

  task automatic test_empty;
    clear_mem();
    run_batch(4'b0000, 4'b0000, 16'h0, '0, '0, 5);
    n_checks++;
    if (res_lat != 1 || res_cyc != 0) begin
      n_fail++; $display("FAIL empty_batch: lat=%0d cyc=%0d required 1 0", res_lat, res_cyc);
    end
  endtask

  task automatic rand_batch(input int hold);
    logic [127:0] a, d;
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w = $urandom; w[7:6] = 2'(k); a[k*32 +: 32] = w;
      d[k*32 +: 32] = $urandom;
      m_stall[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(LIMIT, LIMIT + 2))
                                                : int'($urandom_range(0, LIMIT - 1));
      m_err[k]   = ($urandom_range(0, 7) == 0);
      m_rdata[k] = $urandom;
    end
    run_batch(4'($urandom_range(0, 15)), 4'($urandom), 16'($urandom), a, d, hold);
  endtask

  task automatic test_back_to_back;
    for (int b = 0; b < 3; b++) rand_batch(0);
  endtask

  task automatic test_random;
    for (int b = 0; b < 40; b++) rand_batch(int'($urandom_range(0, 3)));
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_cen = 4'b0011; req_wen = 4'b0000;
    req_addr = {64'h0, 32'h2040, 32'h2000};
    @(negedge g_clk);
    req_valid = 1'b0; cop_mem_stall = 1'b0; cop_mem_rdata = 32'hCAFEF00D;
    @(negedge g_clk);
    cop_mem_stall = 1'b1;
    @(negedge g_clk);
    g_resetn = 1'b0;
    @(negedge g_clk);
    g_resetn = 1'b1; cop_mem_stall = 1'b0;
    n_checks++;
    if (cop_mem_cen !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ctrl: cen=%b ready=%b valid=%b required 0 1 0", cop_mem_cen, req_ready, rsp_valid);
    end
    n_checks++;
    if (rsp_error !== 1'b0 || rsp_rdata !== '0) begin
      n_fail++; $display("FAIL reset_mid_rsp: error=%b rdata=%h required 0 0", rsp_error, rsp_rdata);
    end
    @(negedge g_clk);
    rand_batch(1);
  endtask

`ifdef SCARV_COP_MEM_SEQ_ABORT_EN
  task automatic test_abort;
    int seen;
    req_valid = 1'b1; req_cen = 4'b0111; req_wen = 4'b0000;
    req_addr = {32'h0, 32'h90, 32'h50, 32'h10};
    @(negedge g_clk);
    req_valid = 1'b0; cop_mem_stall = 1'b0; cop_mem_error = 1'b0; cop_mem_rdata = 32'h11111111;
    n_checks++;
    if (cop_mem_cen !== 1'b1 || cop_mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL abort_slot0: cen=%b addr=%h required 1 10", cop_mem_cen, cop_mem_addr);
    end
    @(negedge g_clk);
    n_checks++;
    if (cop_mem_cen !== 1'b1 || cop_mem_addr !== 32'h50) begin
      n_fail++; $display("FAIL abort_slot1: cen=%b addr=%h required 1 50", cop_mem_cen, cop_mem_addr);
    end
    abort = 1'b1;
    @(negedge g_clk);
    abort = 1'b0;
    n_checks++;
    if (cop_mem_cen !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_issue: cen=%b valid=%b ready=%b required 0 0 1", cop_mem_cen, rsp_valid, req_ready);
    end
    seen = 0;
    repeat (4) begin
      @(negedge g_clk);
      if (cop_mem_cen !== 1'b0 || rsp_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_quiet: %0d active cycles required 0", seen);
    end
    req_valid = 1'b1; req_cen = 4'b0000;
    @(negedge g_clk);
    req_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL abort_resp_pre: valid=%b required 1", rsp_valid);
    end
    abort = 1'b1;
    @(negedge g_clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_resp: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
    end
    req_valid = 1'b1;
    @(negedge g_clk);
    req_valid = 1'b0; abort = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL abort_idle: valid=%b required 1", rsp_valid);
    end
    rsp_ack = 1'b1;
    @(negedge g_clk);
    rsp_ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_read_two();
    test_write_stall();
    test_error();
    test_watchdog();
    test_empty();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef SCARV_COP_MEM_SEQ_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
